// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contents: default widths, RV64 load/store funct3 encodings, FSM state codes,
// and the helpers that decode access size into a byte mask and an alignment check.
package lsu_mem_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int ADDR_W_DEF = 32;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Byte strobes for an access of 1/2/4/8 bytes starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // True when the beat offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load alignment: shifts the addressed bytes of a read beat down to lane 0,
// truncates to the access size and sign- or zero-extends to XLEN.
// Ports: beat (read beat), offset (byte offset within beat), funct3 (load kind),
// result (extended load value; 0 for an unknown funct3).
module lsu_load_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] beat,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = beat >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:   result = shifted;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  result = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit. Accepts one instruction at a time from EX/MEM,
// performs at most one data-bus transaction and presents the result to mem_wb_reg.
// Ports:
//   in_*            instruction from EX/MEM (valid/ready handshake, in_ready high only in IDLE)
//   mem_req_*       bus request: mem_addr/mem_wen/mem_wdata/mem_wmask held while mem_req_valid
//   mem_rsp_*       bus response: read beat or write ack, one cycle pulse
//   out_*           result toward mem_wb_reg (valid/ready handshake)
//   dbg_state       current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// once valid is raised, the payload stays stable and valid stays high until that transfer.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_exu_result,
  input  logic [XLEN-1:0]   in_x_rs2,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [2:0]        in_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [XLEN-1:0]   out_exu_result,
  output logic [XLEN-1:0]   out_lsu_r_data,
  output logic              out_misalign,
  output lsu_state_e        dbg_state
);

  lsu_state_e      state_q, state_d;
  logic [31:0]     pc_q, inst_q;
  logic [XLEN-1:0] exu_q, rs2_q, rdata_q, load_data;
  logic [2:0]      funct3_q;
  logic            store_q, misalign_q;

  // Decode of the incoming instruction, used only on the accept cycle.
  // A request with both enables set is a store.
  logic is_mem, illegal, fault, accept;
  assign is_mem  = in_mem_r_en | in_mem_w_en;
  assign illegal = in_mem_w_en ? in_funct3[2] : (in_funct3 == 3'b111);
  assign fault   = is_mem & (illegal | is_misaligned(in_funct3[1:0], in_exu_result[2:0]));
  assign accept  = (state_q == S_IDLE) & in_valid;

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .beat   (mem_rsp_rdata),
    .offset (exu_q[2:0]),
    .funct3 (funct3_q),
    .result (load_data)
  );

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (is_mem && !fault) ? S_REQ : S_DONE;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inst_q     <= '0;
      exu_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q       <= in_pc;
        inst_q     <= in_inst;
        exu_q      <= in_exu_result;
        rs2_q      <= in_x_rs2;
        funct3_q   <= in_funct3;
        store_q    <= in_mem_w_en;
        misalign_q <= fault;
        rdata_q    <= '0;
      end
      // Write acks also arrive here; only loads capture the beat.
      if (state_q == S_WAIT && mem_rsp_valid && !store_q) rdata_q <= load_data;
    end
  end

  // Bus fields are forced to 0 outside REQ so idle/reset values are clean.
  logic req_store;
  assign req_store = (state_q == S_REQ) & store_q;

  assign mem_addr  = (state_q == S_REQ) ? {exu_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wen   = req_store;
  assign mem_wdata = req_store ? (rs2_q << {exu_q[2:0], 3'b000}) : '0;
  assign mem_wmask = req_store ? (size_mask(funct3_q[1:0]) << exu_q[2:0]) : '0;

  assign out_pc         = pc_q;
  assign out_inst       = inst_q;
  assign out_exu_result = exu_q;
  assign out_lsu_r_data = rdata_q;
  assign out_misalign   = misalign_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  import lsu_mem_stage_pkg::*;

  localparam int OW = 193;  // {pc, inst, exu, rdata, misalign}
  localparam int BW = 105;  // {addr, wen, wdata, wmask}

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [63:0] in_exu_result, in_x_rs2;
  logic        in_mem_r_en, in_mem_w_en;
  logic [2:0]  in_funct3;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [63:0] out_exu_result, out_lsu_r_data;
  logic        out_misalign;
  lsu_state_e  dbg_state;

  lsu_mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_exu_result(in_exu_result), .in_x_rs2(in_x_rs2),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_funct3(in_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_exu_result(out_exu_result), .out_lsu_r_data(out_lsu_r_data),
    .out_misalign(out_misalign), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  logic [BW-1:0] bus_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-by-byte view of the access.
  function automatic void model(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [63:0] exu, input logic [63:0] rs2,
                                input logic r_en, input logic w_en, input logic [2:0] f3,
                                input logic [63:0] beat, input bit push,
                                output logic [OW-1:0] e, output logic [BW-1:0] b,
                                output bit has_bus);
    int size, off;
    bit mem_op, store, illegal, mis;
    logic [63:0] rd, wd;
    logic [7:0] wm;
    size    = 1 << f3[1:0];
    off     = int'(exu[2:0]);
    mem_op  = r_en | w_en;
    store   = w_en;
    illegal = store ? f3[2] : (f3 == 3'd7);
    mis     = mem_op && (illegal || (off % size) != 0);
    rd = '0; wd = '0; wm = '0;
    if (mem_op && !store && !mis) begin
      for (int bi = 0; bi < size; bi++) rd[8*bi +: 8] = beat[8*(off+bi) +: 8];
      if (!f3[2] && rd[8*size-1])
        for (int bi = size; bi < 8; bi++) rd[8*bi +: 8] = 8'hFF;
    end
    if (mem_op && store && !mis)
      for (int bi = 0; bi < size; bi++) begin
        wm[off+bi] = 1'b1;
        wd[8*(off+bi) +: 8] = rs2[8*bi +: 8];
      end
    e = {pc, inst, exu, rd, mis};
    b = {exu[31:3], 3'b000, store, wd, wm};
    has_bus = mem_op && !mis;
    if (push) begin
      exp_q.push_back(e);
      if (has_bus) bus_q.push_back(b);
    end
  endfunction

  // ---------------- bus responder ----------------
  int req_stall_left = 0;
  int rsp_wait = 0;
  bit rsp_pending = 0;
  logic [63:0] beat_v = '0;

  initial begin : responder
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      mem_req_ready = 1'b0;
      if (rsp_pending) begin
        if (rsp_wait > 0) rsp_wait--;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = beat_v;
          rsp_pending   = 0;
        end
      end
      if (mem_req_valid && !rst) begin
        if (req_stall_left > 0) req_stall_left--;
        else begin
          mem_req_ready = 1'b1;
          rsp_pending   = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [OW-1:0] e;
    logic [BW-1:0] b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (mem_req_valid) begin
          chk("req_in_ready", {63'd0, in_ready}, 64'd0);
          if (bus_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
          else begin
            b = bus_q[0];
            chk("mem_addr",  {32'd0, mem_addr}, {32'd0, b[104:73]});
            chk("mem_wen",   {63'd0, mem_wen}, {63'd0, b[72]});
            chk("mem_wdata", mem_wdata, b[71:8]);
            chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, b[7:0]});
            if (mem_req_ready) void'(bus_q.pop_front());
          end
        end
        if (out_valid) begin
          chk("out_in_ready", {63'd0, in_ready}, 64'd0);
          if (exp_q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
          else begin
            e = exp_q[0];
            chk("out_pc",       {32'd0, out_pc}, {32'd0, e[192:161]});
            chk("out_inst",     {32'd0, out_inst}, {32'd0, e[160:129]});
            chk("out_exu",      out_exu_result, e[128:65]);
            chk("out_rdata",    out_lsu_r_data, e[64:1]);
            chk("out_misalign", {63'd0, out_misalign}, {63'd0, e[0]});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_state"}, {62'd0, dbg_state}, {62'd0, S_IDLE});
    chk({tag, "_ctl"}, {60'd0, mem_req_valid, mem_wen, out_valid, out_misalign}, 64'd0);
    chk({tag, "_addr_mask"}, {24'd0, mem_addr, mem_wmask}, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_pc_inst"}, {out_pc, out_inst}, 64'd0);
    chk({tag, "_exu"}, out_exu_result, 64'd0);
    chk({tag, "_rdata"}, out_lsu_r_data, 64'd0);
  endtask

  task automatic wait_ready_and_accept(input string tag);
    int tmo;
    tmo = 0;
    @(negedge clk);
    while (!in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!in_ready) chk({tag, "_accept_timeout"}, 64'd1, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [63:0] exu, input logic [63:0] rs2,
                        input logic r_en, input logic w_en, input logic [2:0] f3,
                        input logic [63:0] beat, input int req_stall, input int out_stall,
                        input int exp_lat);
    logic [OW-1:0] e;
    logic [BW-1:0] b;
    bit hb;
    int n;
    model(pc, inst, exu, rs2, r_en, w_en, f3, beat, 1'b1, e, b, hb);
    @(posedge clk);
    #1;
    in_pc = pc; in_inst = inst; in_exu_result = exu; in_x_rs2 = rs2;
    in_mem_r_en = r_en; in_mem_w_en = w_en; in_funct3 = f3; in_valid = 1'b1;
    req_stall_left = req_stall; rsp_wait = 0; beat_v = beat;
    out_ready = (out_stall == 0);
    wait_ready_and_accept(tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 60);
    if (!out_valid) chk({tag, "_out_timeout"}, 64'd1, 64'd0);
    else if (exp_lat > 0) chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    if (out_stall > 0) begin
      repeat (out_stall) @(negedge clk);
      out_ready = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [OW-1:0] e;
    logic [BW-1:0] b;
    bit hb;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_exu_result = '0;
    in_x_rs2 = '0; in_mem_r_en = 1'b0; in_mem_w_en = 1'b0; in_funct3 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed pins on the model itself.
    model(32'h0, 32'h0, 64'h8000_0010, 64'h0, 1, 0, F3_LD, 64'h1122334455667788, 0, e, b, hb);
    chk("pin_ld", e[64:1], 64'h1122334455667788);
    model(32'h0, 32'h0, 64'h8000_0013, 64'h0, 1, 0, F3_LB, 64'h0000_0000_8000_0000, 0, e, b, hb);
    chk("pin_lb", e[64:1], 64'hFFFF_FFFF_FFFF_FF80);
    model(32'h0, 32'h0, 64'h8000_0013, 64'h0, 1, 0, F3_LBU, 64'h0000_0000_8000_0000, 0, e, b, hb);
    chk("pin_lbu", e[64:1], 64'h80);
    model(32'h0, 32'h0, 64'h8000_0004, 64'hDEADBEEF, 0, 1, F3_SW, 64'h0, 0, e, b, hb);
    chk("pin_sw_addr", {32'd0, b[104:73]}, 64'h8000_0000);
    chk("pin_sw_mask", {55'd0, b[72], b[7:0]}, 64'h1F0);
    chk("pin_sw_wdata", b[71:8], 64'hDEADBEEF_0000_0000);
    chk("pin_sw_rdata", e[64:1], 64'h0);
    model(32'h0, 32'h0, 64'h8000_0002, 64'h0, 1, 0, F3_LW, 64'h0, 0, e, b, hb);
    chk("pin_lw_mis", {62'd0, e[0], hb}, 64'h2);

    // Directed table: tag, pc, inst, exu, rs2, r_en, w_en, funct3, beat, req_stall, out_stall, latency
    run_op("ld",    32'h100, 32'h0000_3003, 64'h8000_0010, 64'h0,      1, 0, F3_LD,  64'h1122334455667788, 0, 0, 3);
    run_op("lb",    32'h104, 32'h0000_0003, 64'h8000_0013, 64'h0,      1, 0, F3_LB,  64'h0000_0000_8000_0000, 0, 0, 3);
    run_op("lbu",   32'h108, 32'h0000_4003, 64'h8000_0013, 64'h0,      1, 0, F3_LBU, 64'h0000_0000_8000_0000, 0, 0, 3);
    run_op("sw",    32'h10C, 32'h0000_2023, 64'h8000_0004, 64'hDEADBEEF, 0, 1, F3_SW, 64'h0, 0, 0, 3);
    run_op("lw_mis",32'h110, 32'h0000_2003, 64'h8000_0002, 64'h0,      1, 0, F3_LW,  64'h0, 0, 0, 1);
    run_op("sd_stl",32'h114, 32'h0000_3023, 64'h8000_0008, 64'h0123456789ABCDEF, 0, 1, F3_SD, 64'h0, 5, 4, 8);
    run_op("lh",    32'h118, 32'h0000_1003, 64'h8000_0006, 64'h0,      1, 0, F3_LH,  64'hBEEF_0000_0000_0000, 0, 0, 3);
    run_op("lwu",   32'h11C, 32'h0000_6003, 64'h8000_0004, 64'h0,      1, 0, F3_LWU, 64'hF000_0001_0000_0000, 0, 0, 3);
    run_op("alu",   32'h120, 32'h0000_0033, 64'h1234,      64'h55,     0, 0, 3'b011, 64'h0, 0, 0, 1);
    run_op("rw_sb", 32'h124, 32'h0000_0023, 64'h8000_0007, 64'hAB,     1, 1, F3_SB,  64'h0, 0, 0, 3);
    run_op("ld_ill",32'h128, 32'h0000_7003, 64'h8000_0000, 64'h0,      1, 0, 3'b111, 64'h0, 0, 0, 1);
    run_op("st_ill",32'h12C, 32'h0000_4023, 64'h8000_0000, 64'h77,     0, 1, 3'b100, 64'h0, 0, 0, 1);
    run_op("sh_mis",32'h130, 32'h0000_1023, 64'h8000_0005, 64'h1234,   0, 1, F3_SH,  64'h0, 0, 0, 1);
    run_op("lhu",   32'h134, 32'h0000_5003, 64'h8000_0002, 64'h0,      1, 0, F3_LHU, 64'h0000_0000_8001_0000, 0, 2, 3);

    // Reset while waiting for a read response; the late response must be ignored.
    model(32'h200, 32'h0000_3003, 64'h8000_0008, 64'h0, 1, 0, F3_LD, 64'hCAFE, 0, e, b, hb);
    bus_q.push_back(b);
    @(posedge clk);
    #1;
    in_pc = 32'h200; in_inst = 32'h0000_3003; in_exu_result = 64'h8000_0008; in_x_rs2 = '0;
    in_mem_r_en = 1'b1; in_mem_w_en = 1'b0; in_funct3 = F3_LD; in_valid = 1'b1;
    req_stall_left = 0; rsp_wait = 4; beat_v = 64'hCAFE;
    wait_ready_and_accept("rst_wait");
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_wait_state", {62'd0, dbg_state}, {62'd0, S_WAIT});
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("mid_reset");
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("late_rsp_no_out", {62'd0, out_valid, mem_req_valid}, 64'd0);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
